// File: rtl/player_ctrl.sv
// player_ctrl: one player's sprite position, button-driven stepping, explosion and
// enemy hit detection, life counter with respawn and post-hit invulnerability,
// plus sprite-hit / row / col lookups for the sprite ROM and pixel mux.
module player_ctrl #(
  parameter int MIN_X      = 143,
  parameter int MAX_X      = 784,
  parameter int MIN_Y      = 34,
  parameter int MAX_Y      = 516,
  parameter int SPR_W      = 16,
  parameter int SPR_H      = 16,
  parameter int START_X    = 143,
  parameter int START_Y    = 34,
  parameter int STEP_DIV   = 1400000,
  parameter int CNT_W      = 21,
  parameter int BLAST_LEN  = 48,
  parameter int BEAM_W     = 16,
  parameter int LIVES      = 3,
  parameter int INVULN_CYC = 4000000,
  parameter int INV_W      = 22
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic [3:0]  blocked,
  input  logic        expl_pulse,
  input  logic [9:0]  e_x,
  input  logic [9:0]  e_y,
  input  logic        enemy_hit,
  input  logic [9:0]  v_x,
  input  logic [9:0]  v_y,
  output logic [9:0]  b_x,
  output logic [9:0]  b_y,
  output logic [1:0]  dir,
  output logic [2:0]  lives,
  output logic        invuln,
  output logic        hit_pulse,
  output logic        game_over,
  output logic        sprite_on,
  output logic [3:0]  spr_row,
  output logic [3:0]  spr_col
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MV_L = 3'd1,
    MV_R = 3'd2,
    MV_U = 3'd3,
    MV_D = 3'd4
  } state_t;

  localparam logic [9:0]         MIN_X_C     = 10'(MIN_X);
  localparam logic [9:0]         RIGHT_LIM_C = 10'(MAX_X - SPR_W);
  localparam logic [9:0]         MIN_Y_C     = 10'(MIN_Y);
  localparam logic [9:0]         DOWN_LIM_C  = 10'(MAX_Y - SPR_H);
  localparam logic [9:0]         START_X_C   = 10'(START_X);
  localparam logic [9:0]         START_Y_C   = 10'(START_Y);
  localparam logic [CNT_W-1:0]   STEP_LAST_C = CNT_W'(STEP_DIV - 1);
  localparam logic [INV_W-1:0]   INV_LOAD_C  = INV_W'(INVULN_CYC - 1);
  localparam logic [2:0]         LIVES_C     = 3'(LIVES);
  localparam logic signed [11:0] BL_C        = 12'(BLAST_LEN);
  localparam logic signed [11:0] BW_M1_C     = 12'(BEAM_W - 1);
  localparam logic signed [11:0] SW_M1_C     = 12'(SPR_W - 1);
  localparam logic signed [11:0] SH_M1_C     = 12'(SPR_H - 1);
  localparam logic [10:0]        SPR_W_M1_U  = 11'(SPR_W - 1);
  localparam logic [10:0]        SPR_H_M1_U  = 11'(SPR_H - 1);

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [9:0]         b_x_r, b_x_s, b_y_r, b_y_s;
  logic [1:0]         dir_r, dir_s;
  logic [2:0]         lives_r, lives_s;
  logic               invuln_r, invuln_s;
  logic [INV_W-1:0]   inv_cnt_r, inv_cnt_s;
  logic               hit_pulse_r, hit_pulse_s;
  logic               game_over_r, game_over_s;

  logic               held_s, legal_s;
  logic [9:0]         nxt_x_s, nxt_y_s;
  logic signed [11:0] sx_s, sy_s, ex_s, ey_s;
  logic               beam_ov_s, hit_ev_s;

  // Inclusive 1-D interval overlap; the rectangle test is the AND of x and y spans.
  function automatic logic span_ov(input logic signed [11:0] a_lo, input logic signed [11:0] a_hi,
                                   input logic signed [11:0] b_lo, input logic signed [11:0] b_hi);
    span_ov = (a_lo <= b_hi) && (b_lo <= a_hi);
  endfunction

  // Signed 12-bit copies keep e-BLAST_LEN negative instead of wrapping near the top/left.
  assign sx_s = $signed({2'b00, b_x_r});
  assign sy_s = $signed({2'b00, b_y_r});
  assign ex_s = $signed({2'b00, e_x});
  assign ey_s = $signed({2'b00, e_y});

  assign beam_ov_s =
      (span_ov(sx_s, sx_s + SW_M1_C, ex_s - BL_C, ex_s + BW_M1_C + BL_C) &&
       span_ov(sy_s, sy_s + SH_M1_C, ey_s, ey_s + BW_M1_C)) ||
      (span_ov(sx_s, sx_s + SW_M1_C, ex_s, ex_s + BW_M1_C) &&
       span_ov(sy_s, sy_s + SH_M1_C, ey_s - BL_C, ey_s + BW_M1_C + BL_C));

  assign hit_ev_s = ((expl_pulse && beam_ov_s) || enemy_hit) && !invuln_r && !game_over_r;

  // Per-direction view: is the active button still held, may we step, and where to.
  always_comb begin
    held_s  = 1'b0;
    legal_s = 1'b0;
    nxt_x_s = b_x_r;
    nxt_y_s = b_y_r;
    case (state_r)
      MV_L: begin
        held_s  = btn_l;
        legal_s = !blocked[0] && (b_x_r > MIN_X_C) && !game_over_r;
        nxt_x_s = b_x_r - 10'd1;
      end
      MV_R: begin
        held_s  = btn_r;
        legal_s = !blocked[1] && (b_x_r < RIGHT_LIM_C) && !game_over_r;
        nxt_x_s = b_x_r + 10'd1;
      end
      MV_U: begin
        held_s  = btn_u;
        legal_s = !blocked[2] && (b_y_r > MIN_Y_C) && !game_over_r;
        nxt_y_s = b_y_r - 10'd1;
      end
      MV_D: begin
        held_s  = btn_d;
        legal_s = !blocked[3] && (b_y_r < DOWN_LIM_C) && !game_over_r;
        nxt_y_s = b_y_r + 10'd1;
      end
      default: begin
        held_s  = 1'b0;
        legal_s = 1'b0;
      end
    endcase
  end

  // Next-state logic: invulnerability countdown, hit handling (wins over a step), FSM.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    b_x_s       = b_x_r;
    b_y_s       = b_y_r;
    dir_s       = dir_r;
    lives_s     = lives_r;
    invuln_s    = invuln_r;
    inv_cnt_s   = inv_cnt_r;
    hit_pulse_s = 1'b0;
    game_over_s = game_over_r;

    if (invuln_r) begin
      if (inv_cnt_r == {INV_W{1'b0}}) begin
        invuln_s = 1'b0;
      end else begin
        inv_cnt_s = inv_cnt_r - INV_W'(1);
      end
    end else begin
      inv_cnt_s = inv_cnt_r;
    end

    if (hit_ev_s) begin
      hit_pulse_s = 1'b1;
      lives_s     = lives_r - 3'd1;
      state_s     = IDLE;
      cnt_s       = {CNT_W{1'b0}};
      if (lives_r == 3'd1) begin
        game_over_s = 1'b1;
      end else begin
        b_x_s     = START_X_C;
        b_y_s     = START_Y_C;
        invuln_s  = 1'b1;
        inv_cnt_s = INV_LOAD_C;
      end
    end else begin
      case (state_r)
        IDLE: begin
          cnt_s = {CNT_W{1'b0}};
          if (btn_l) begin
            state_s = MV_L;
            dir_s   = 2'd2;
          end else if (btn_r) begin
            state_s = MV_R;
            dir_s   = 2'd3;
          end else if (btn_u) begin
            state_s = MV_U;
            dir_s   = 2'd1;
          end else if (btn_d) begin
            state_s = MV_D;
            dir_s   = 2'd0;
          end else begin
            state_s = IDLE;
          end
        end
        MV_L, MV_R, MV_U, MV_D: begin
          if (!held_s) begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
          end else if (cnt_r == STEP_LAST_C) begin
            cnt_s = {CNT_W{1'b0}};
            if (legal_s) begin
              b_x_s = nxt_x_s;
              b_y_s = nxt_y_s;
            end else begin
              b_x_s = b_x_r;
              b_y_s = b_y_r;
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State register with asynchronous active-low reset to the spawn condition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      b_x_r       <= START_X_C;
      b_y_r       <= START_Y_C;
      dir_r       <= 2'd0;
      lives_r     <= LIVES_C;
      invuln_r    <= 1'b0;
      inv_cnt_r   <= {INV_W{1'b0}};
      hit_pulse_r <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      b_x_r       <= b_x_s;
      b_y_r       <= b_y_s;
      dir_r       <= dir_s;
      lives_r     <= lives_s;
      invuln_r    <= invuln_s;
      inv_cnt_r   <= inv_cnt_s;
      hit_pulse_r <= hit_pulse_s;
      game_over_r <= game_over_s;
    end
  end

  assign b_x       = b_x_r;
  assign b_y       = b_y_r;
  assign dir       = dir_r;
  assign lives     = lives_r;
  assign invuln    = invuln_r;
  assign hit_pulse = hit_pulse_r;
  assign game_over = game_over_r;

  // Pixel-side lookups follow the live position with no pipeline delay.
  assign sprite_on = (v_x >= b_x_r) && ({1'b0, v_x} <= ({1'b0, b_x_r} + SPR_W_M1_U)) &&
                     (v_y >= b_y_r) && ({1'b0, v_y} <= ({1'b0, b_y_r} + SPR_H_M1_U));
  assign spr_row   = v_y[3:0] - b_y_r[3:0];
  assign spr_col   = v_x[3:0] - b_x_r[3:0];

endmodule

// File: tb/tb_player_ctrl.sv
// tb_player_ctrl: table-driven checks, directed multi-cycle sequences and a randomized
// run, all compared against a behavioural player model kept in this bench.
module tb_player_ctrl;
  localparam int MIN_X = 143, MAX_X = 784, MIN_Y = 34, MAX_Y = 516;
  localparam int SPR_W = 16, SPR_H = 16, START_X = 143, START_Y = 34;
  localparam int STEP_DIV = 4, BLAST_LEN = 48, BEAM_W = 16, LIVES = 3, INVULN_CYC = 20;

  logic clk, reset, btn_l, btn_r, btn_u, btn_d, expl_pulse, enemy_hit;
  logic [3:0] blocked;
  logic [9:0] e_x, e_y, v_x, v_y, b_x, b_y;
  logic [1:0] dir;
  logic [2:0] lives;
  logic invuln, hit_pulse, game_over, sprite_on;
  logic [3:0] spr_row, spr_col;

  player_ctrl #(.STEP_DIV(STEP_DIV), .CNT_W(3), .INVULN_CYC(INVULN_CYC), .INV_W(5)) dut (
    .clk(clk), .reset(reset), .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
    .blocked(blocked), .expl_pulse(expl_pulse), .e_x(e_x), .e_y(e_y), .enemy_hit(enemy_hit),
    .v_x(v_x), .v_y(v_y), .b_x(b_x), .b_y(b_y), .dir(dir), .lives(lives), .invuln(invuln),
    .hit_pulse(hit_pulse), .game_over(game_over), .sprite_on(sprite_on),
    .spr_row(spr_row), .spr_col(spr_col));

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Model: position, facing, lives, remaining invulnerable cycles, held move (-1 none,
  // 0=L 1=R 2=U 3=D) and cycles spent holding it since the last step.
  int m_x, m_y, m_dir, m_lives, m_inv, m_hitp, m_go, m_mv, m_ticks;
  int dcode[4] = '{2, 3, 1, 0};

  typedef struct { logic [9:0] vx; logic [9:0] vy; logic on; logic [3:0] row; logic [3:0] col; } spr_vec_t;
  typedef struct { int ex; int ey; logic hit; } hit_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int clamp10(input int v);
    return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
  endfunction

  function automatic bit ov(input int a0, input int a1, input int b0, input int b1);
    return (a0 <= b1) && (b0 <= a1);
  endfunction

  // A plus-shaped blast: a horizontal and a vertical bar through the centre tile.
  function automatic bit beam_hit(input int px, input int py, input int ex, input int ey);
    bit horiz, vert;
    horiz = ov(px, px + SPR_W - 1, ex - BLAST_LEN, ex + BEAM_W - 1 + BLAST_LEN) &&
            ov(py, py + SPR_H - 1, ey, ey + BEAM_W - 1);
    vert  = ov(px, px + SPR_W - 1, ex, ex + BEAM_W - 1) &&
            ov(py, py + SPR_H - 1, ey - BLAST_LEN, ey + BEAM_W - 1 + BLAST_LEN);
    return horiz || vert;
  endfunction

  function automatic void model_reset();
    m_x = START_X; m_y = START_Y; m_dir = 0; m_lives = LIVES; m_inv = 0;
    m_hitp = 0; m_go = 0; m_mv = -1; m_ticks = 0;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_step();
    bit [3:0] b;
    bit hit, found;
    b = {btn_d, btn_u, btn_r, btn_l};
    hit = (m_go == 0) && (m_inv == 0) && ((expl_pulse && beam_hit(m_x, m_y, e_x, e_y)) || enemy_hit);
    m_hitp = hit;
    if (m_inv > 0) m_inv--;
    if (hit) begin
      m_lives--; m_mv = -1; m_ticks = 0;
      if (m_lives == 0) m_go = 1;
      else begin m_x = START_X; m_y = START_Y; m_inv = INVULN_CYC; end
    end else if (m_mv < 0) begin
      found = 0;
      for (int k = 0; k < 4; k++)
        if (!found && b[k]) begin found = 1; m_mv = k; m_dir = dcode[k]; end
    end else if (!b[m_mv]) begin
      m_mv = -1; m_ticks = 0;
    end else begin
      m_ticks++;
      if (m_ticks == STEP_DIV) begin
        m_ticks = 0;
        if (!blocked[m_mv] && m_go == 0) begin
          case (m_mv)
            0: if (m_x > MIN_X) m_x--;
            1: if (m_x < MAX_X - SPR_W) m_x++;
            2: if (m_y > MIN_Y) m_y--;
            3: if (m_y < MAX_Y - SPR_H) m_y++;
            default: ;
          endcase
        end
      end
    end
  endfunction

  // Compare every output with the model; pixel probes land on or near the sprite half the time.
  task automatic compare_all();
    if ($urandom_range(0, 1) == 1) begin
      v_x = 10'(clamp10(m_x + int'($urandom_range(0, 20)) - 2));
      v_y = 10'(clamp10(m_y + int'($urandom_range(0, 20)) - 2));
    end else begin
      v_x = 10'($urandom_range(0, 1023));
      v_y = 10'($urandom_range(0, 1023));
    end
    #1;
    chk("b_x", b_x, m_x);
    chk("b_y", b_y, m_y);
    chk("dir", dir, m_dir);
    chk("lives", lives, m_lives);
    chk("invuln", invuln, (m_inv > 0) ? 1 : 0);
    chk("hit_pulse", hit_pulse, m_hitp);
    chk("game_over", game_over, m_go);
    chk("sprite_on", sprite_on, (v_x >= m_x && v_x <= m_x + SPR_W - 1 &&
                                 v_y >= m_y && v_y <= m_y + SPR_H - 1) ? 1 : 0);
    chk("spr_row", spr_row, (int'(v_y) - m_y) & 15);
    chk("spr_col", spr_col, (int'(v_x) - m_x) & 15);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_inputs();
    btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0; btn_d = 1'b0; blocked = 4'd0;
    expl_pulse = 1'b0; enemy_hit = 1'b0; e_x = 10'd0; e_y = 10'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    compare_all();
  endtask

  // Pull reset low between edges and check outputs before any further clock edge.
  task automatic async_reset_check();
    #1 reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("ar_b_y", b_y, START_Y);
    chk("ar_lives", lives, LIVES);
    chk("ar_game_over", game_over, 0);
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic pulse_expl(input int ex, input int ey);
    e_x = 10'(ex); e_y = 10'(ey); expl_pulse = 1'b1;
    tick();
    expl_pulse = 1'b0;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    spr_vec_t svec[8];
    hit_vec_t hvec[13];
    int n, pulses;
    svec = '{'{10'd143, 10'd34, 1'b1, 4'd0, 4'd0},    '{10'd158, 10'd49, 1'b1, 4'd15, 4'd15},
             '{10'd142, 10'd34, 1'b0, 4'd0, 4'd15},   '{10'd159, 10'd40, 1'b0, 4'd6, 4'd0},
             '{10'd150, 10'd33, 1'b0, 4'd15, 4'd7},   '{10'd150, 10'd50, 1'b0, 4'd0, 4'd7},
             '{10'd0, 10'd0, 1'b0, 4'd14, 4'd1},      '{10'd1023, 10'd1023, 1'b0, 4'd13, 4'd0}};
    hvec = '{'{206, 34, 1'b1}, '{207, 34, 1'b0}, '{80, 49, 1'b1}, '{79, 49, 1'b0},
             '{100, 50, 1'b0}, '{128, 97, 1'b1}, '{128, 98, 1'b0}, '{127, 97, 1'b0},
             '{158, 60, 1'b1}, '{159, 60, 1'b0}, '{140, 10, 1'b1}, '{140, 0, 1'b1},
             '{1023, 1023, 1'b0}};
    clear_inputs();
    v_x = 10'd0; v_y = 10'd0;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all();
    chk("rst_b_x", b_x, 143);
    chk("rst_lives", lives, 3);
    reset = 1'b1;

    // Sprite window table at the spawn position.
    foreach (svec[i]) begin
      v_x = svec[i].vx; v_y = svec[i].vy;
      #1;
      chk("tbl_sprite_on", sprite_on, svec[i].on);
      chk("tbl_spr_row", spr_row, svec[i].row);
      chk("tbl_spr_col", spr_col, svec[i].col);
    end

    // Blast geometry table: each entry from a fresh reset at (143,34).
    foreach (hvec[i]) begin
      do_reset();
      pulse_expl(hvec[i].ex, hvec[i].ey);
      chk("tbl_hit_pulse", hit_pulse, hvec[i].hit);
      chk("tbl_hit_lives", lives, hvec[i].hit ? 2 : 3);
    end

    // Hold right for 20 cycles: four steps.
    do_reset();
    btn_r = 1'b1;
    repeat (20) tick();
    chk("move_r_b_x", b_x, 147);
    chk("move_r_dir", dir, 3);
    btn_r = 1'b0; tick();

    // Left wall, then a blocked move to the right.
    btn_l = 1'b1;
    repeat (40) tick();
    chk("wall_l_b_x", b_x, 143);
    btn_l = 1'b0; tick();
    blocked = 4'b0010; btn_r = 1'b1;
    repeat (20) tick();
    chk("blocked_r_b_x", b_x, 143);
    btn_r = 1'b0; blocked = 4'd0; tick();

    // Walk to (200,100), then miss and hit with explosions.
    btn_r = 1'b1;
    for (int i = 0; i < 400 && b_x != 10'd200; i++) tick();
    btn_r = 1'b0; tick();
    btn_d = 1'b1;
    for (int i = 0; i < 400 && b_y != 10'd100; i++) tick();
    btn_d = 1'b0; tick();
    chk("at_x", b_x, 200);
    chk("at_y", b_y, 100);
    pulse_expl(300, 200);
    chk("miss_hit_pulse", hit_pulse, 0);
    pulse_expl(232, 100);
    chk("hit_pulse", hit_pulse, 1);
    chk("hit_lives", lives, 2);
    chk("respawn_x", b_x, 143);
    chk("respawn_y", b_y, 34);
    n = 1;
    pulse_expl(150, 40);
    chk("inv_lives", lives, 2);
    chk("inv_hit_pulse", hit_pulse, 0);
    if (invuln) n++;
    for (int i = 0; i < 100 && invuln; i++) begin
      tick();
      if (invuln) n++;
    end
    chk("invuln_len", n, INVULN_CYC);

    // Hit on the same edge as a step: respawn, step discarded.
    btn_r = 1'b1;
    repeat (8) tick();
    chk("pre_step_b_x", b_x, 144);
    enemy_hit = 1'b1; tick();
    enemy_hit = 1'b0; btn_r = 1'b0;
    chk("same_edge_b_x", b_x, 143);
    chk("same_edge_lives", lives, 1);
    chk("same_edge_pulse", hit_pulse, 1);
    for (int i = 0; i < 100 && invuln; i++) tick();
    chk("inv_drop", invuln, 0);

    // Last life: game over, frozen movement, no further hits.
    enemy_hit = 1'b1; tick();
    enemy_hit = 1'b0;
    chk("go_flag", game_over, 1);
    chk("go_lives", lives, 0);
    chk("go_pulse", hit_pulse, 1);
    btn_d = 1'b1;
    repeat (20) tick();
    chk("go_frozen_y", b_y, 34);
    pulses = 0;
    enemy_hit = 1'b1; expl_pulse = 1'b1; e_x = 10'd143; e_y = 10'd34;
    repeat (5) begin tick(); if (hit_pulse) pulses++; end
    enemy_hit = 1'b0; expl_pulse = 1'b0;
    chk("go_no_pulse", pulses, 0);
    btn_d = 1'b1; repeat (2) tick();
    async_reset_check();

    // Asynchronous reset in the middle of a downward move.
    model_reset();
    btn_d = 1'b1;
    repeat (6) tick();
    chk("mv_d_b_y", b_y, 35);
    async_reset_check();

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      if (i % 600 == 0) do_reset();
      if ($urandom_range(0, 7) == 0) {btn_d, btn_u, btn_r, btn_l} = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) blocked = 4'($urandom_range(0, 15));
      expl_pulse = ($urandom_range(0, 9) == 0);
      e_x = 10'(clamp10(m_x + int'($urandom_range(0, 200)) - 100));
      e_y = 10'(clamp10(m_y + int'($urandom_range(0, 200)) - 100));
      enemy_hit = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
